// File: rtl/tpm_pkg.sv
// tpm_pkg: constants and types shared by the three-port request path
// (validity filter and request serializer).
package tpm_pkg;
  localparam int DATA_W = 8;
  localparam logic [1:0] PORT_ID_INVALID = 2'd0;
  localparam logic [1:0] PORT_ID_1 = 2'd1;
  localparam logic [1:0] PORT_ID_2 = 2'd2;
  localparam logic [1:0] PORT_ID_3 = 2'd3;
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        id;
    logic [1:0]        tag;
  } slot_t;
endpackage

// File: rtl/request_serializer.sv
// request_serializer: latches a compacted batch of up to three slots and
// issues it one slot per cycle to memory under a valid/ready handshake.
module request_serializer
  import tpm_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] slot1_in,
  input  logic [1:0]       slot1_id,
  input  logic [1:0]       slot1_tag,
  input  logic             slot1_valid,
  input  logic [WIDTH-1:0] slot2_in,
  input  logic [1:0]       slot2_id,
  input  logic [1:0]       slot2_tag,
  input  logic             slot2_valid,
  input  logic [WIDTH-1:0] slot3_in,
  input  logic [1:0]       slot3_id,
  input  logic [1:0]       slot3_tag,
  input  logic             slot3_valid,
  output logic             in_ready,
  output logic             mem_req_valid,
  output logic [WIDTH-1:0] mem_req_data,
  output logic [1:0]       mem_req_id,
  output logic [1:0]       mem_req_tag,
  input  logic             mem_req_ready,
  output logic             mem_req_last,
  output logic             protocol_err
);
  state_t      state_q;
  slot_t [2:0] slot_q;
  slot_t       cur;
  logic [1:0]  count_q, idx_q, count_d;
  logic        err_q, load, beat, nonprefix;
  // Outputs decode from registered state only, so a stalled beat holds steady
  // and reset drops mem_req_valid asynchronously.
  always_comb begin
    cur = idx_q == 2'd2 ? slot_q[2] : idx_q == 2'd1 ? slot_q[1] : slot_q[0];
    mem_req_valid = state_q == ISSUE;
    mem_req_last = mem_req_valid && idx_q == count_q - 2'd1;
    mem_req_data = mem_req_valid ? cur.data : '0;
    mem_req_id = mem_req_valid ? cur.id : PORT_ID_INVALID;
    mem_req_tag = mem_req_valid ? cur.tag : 2'd0;
    in_ready = !mem_req_valid || (mem_req_last && mem_req_ready);
    load = in_ready && slot1_valid;
    beat = mem_req_valid && mem_req_ready;
    count_d = !slot2_valid ? 2'd1 : slot3_valid ? 2'd3 : 2'd2;
    nonprefix = (!slot1_valid && (slot2_valid || slot3_valid)) ||
                (slot1_valid && !slot2_valid && slot3_valid);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      count_q <= 2'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      if (in_ready && nonprefix) err_q <= 1'b1;
      if (load) begin
        slot_q[0] <= '{data: slot1_in, id: slot1_id, tag: slot1_tag};
        slot_q[1] <= '{data: slot2_in, id: slot2_id, tag: slot2_tag};
        slot_q[2] <= '{data: slot3_in, id: slot3_id, tag: slot3_tag};
        count_q   <= count_d;
        idx_q     <= 2'd0;
        state_q   <= ISSUE;
      end else if (beat) begin
        if (mem_req_last) state_q <= IDLE;
        else idx_q <= idx_q + 2'd1;
      end
    end
  end
  assign protocol_err = err_q;
endmodule
